// File: rtl/stopwatch_display_if.sv
// Bundle between the stopwatch core and its display back-end: the centisecond
// count in, and the decoded digits, segment patterns and status out.
interface stopwatch_display_if;
    logic [18:0] time_in;
    logic [23:0] bcd_out;
    logic [6:0]  hex5;
    logic [6:0]  hex4;
    logic [6:0]  hex3;
    logic [6:0]  hex2;
    logic [6:0]  hex1;
    logic [6:0]  hex0;
    logic        busy;
    logic        done;
    logic        ovf;

    modport master (
        output time_in,
        input  bcd_out, hex5, hex4, hex3, hex2, hex1, hex0, busy, done, ovf
    );

    modport slave (
        input  time_in,
        output bcd_out, hex5, hex4, hex3, hex2, hex1, hex0, busy, done, ovf
    );
endinterface

// File: rtl/stopwatch_display.sv
// Converts a centisecond count into MM:SS.cc digits using fixed-latency
// restoring dividers, then drives six seven-segment digits.
module stopwatch_display #(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned MAX_CS         = 360000
) (
    input logic                clk,
    input logic                rst,
    stopwatch_display_if.slave bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DIV_MIN = 3'd1;
    localparam logic [2:0] DIV_SEC = 3'd2;
    localparam logic [2:0] DIGITS  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_DASH = SEG_ACTIVE_LOW ? 7'h3F : 7'h40;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = 7'h7F;
        endcase
        return SEG_ACTIVE_LOW ? c : ~c;
    endfunction

    // One restoring step of a 7-bit divide-by-10: returns {quotient, remainder}.
    function automatic logic [10:0] div10_step(input logic [6:0] q, input logic [3:0] r);
        logic [4:0] t;
        logic       ge;
        t  = {r, q[6]};
        ge = (t >= 5'd10);
        return {q[5:0], ge, (ge ? 4'(t - 5'd10) : t[3:0])};
    endfunction

    logic [2:0]  state;
    logic        first;
    logic [18:0] last_val;
    logic [18:0] work;
    logic [12:0] rem;
    logic [4:0]  cnt;
    logic        ovf_pend;
    logic [6:0]  min_q;
    logic [6:0]  sec_q;
    logic [6:0]  cs_q;
    logic [3:0]  min_r;
    logic [3:0]  sec_r;
    logic [3:0]  cs_r;

    logic [13:0] divisor;
    logic [13:0] trial;
    logic        q_bit;
    logic [12:0] rem_next;
    logic [18:0] work_next;
    logic [10:0] min_step;
    logic [10:0] sec_step;
    logic [10:0] cs_step;

    // Shared long-division datapath: the dividend shifts out of the top of
    // work while quotient bits shift into the bottom.
    always_comb begin
        divisor   = (state == DIV_MIN) ? 14'd6000 : 14'd100;
        trial     = {rem, work[18]};
        q_bit     = (trial >= divisor);
        rem_next  = q_bit ? 13'(trial - divisor) : trial[12:0];
        work_next = {work[17:0], q_bit};
        min_step  = div10_step(min_q, min_r);
        sec_step  = div10_step(sec_q, sec_r);
        cs_step   = div10_step(cs_q, cs_r);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            first       <= 1'b1;
            last_val    <= '0;
            work        <= '0;
            rem         <= '0;
            cnt         <= '0;
            ovf_pend    <= 1'b0;
            min_q       <= '0;
            sec_q       <= '0;
            cs_q        <= '0;
            min_r       <= '0;
            sec_r       <= '0;
            cs_r        <= '0;
            bus.bcd_out <= '0;
            bus.hex5    <= SEG_OFF;
            bus.hex4    <= SEG_OFF;
            bus.hex3    <= SEG_OFF;
            bus.hex2    <= SEG_OFF;
            bus.hex1    <= SEG_OFF;
            bus.hex0    <= SEG_OFF;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.ovf     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (first || (bus.time_in != last_val)) begin
                        work     <= bus.time_in;
                        last_val <= bus.time_in;
                        first    <= 1'b0;
                        ovf_pend <= (32'(bus.time_in) >= MAX_CS);
                        rem      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= DIV_MIN;
                    end
                end
                DIV_MIN: begin
                    work <= work_next;
                    rem  <= rem_next;
                    cnt  <= cnt + 5'd1;
                    // Last minute bit: stash minutes and park the remainder at
                    // the top of work so the seconds divide reuses the datapath.
                    if (cnt == 5'd18) begin
                        min_q <= {1'b0, work[4:0], q_bit};
                        work  <= {rem_next, 6'd0};
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV_SEC;
                    end
                end
                DIV_SEC: begin
                    work <= work_next;
                    rem  <= rem_next;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd12) begin
                        sec_q <= {work[5:0], q_bit};
                        cs_q  <= rem_next[6:0];
                        min_r <= '0;
                        sec_r <= '0;
                        cs_r  <= '0;
                        cnt   <= '0;
                        state <= DIGITS;
                    end
                end
                DIGITS: begin
                    {min_q, min_r} <= min_step;
                    {sec_q, sec_r} <= sec_step;
                    {cs_q, cs_r}   <= cs_step;
                    cnt            <= cnt + 5'd1;
                    if (cnt == 5'd6) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ovf_pend) begin
                        bus.bcd_out <= 24'hFFFFFF;
                        bus.hex5    <= SEG_DASH;
                        bus.hex4    <= SEG_DASH;
                        bus.hex3    <= SEG_DASH;
                        bus.hex2    <= SEG_DASH;
                        bus.hex1    <= SEG_DASH;
                        bus.hex0    <= SEG_DASH;
                    end else begin
                        bus.bcd_out <= {min_q[3:0], min_r, sec_q[3:0], sec_r, cs_q[3:0], cs_r};
                        bus.hex5    <= seg_code(min_q[3:0]);
                        bus.hex4    <= seg_code(min_r);
                        bus.hex3    <= seg_code(sec_q[3:0]);
                        bus.hex2    <= seg_code(sec_r);
                        bus.hex1    <= seg_code(cs_q[3:0]);
                        bus.hex0    <= seg_code(cs_r);
                    end
                    bus.ovf  <= ovf_pend;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display: hand-computed digits, segment codes
// and cycle-exact done/busy timing around each conversion.
module tb_stopwatch_display;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stopwatch_display_if sw();

    stopwatch_display dut (
        .clk (clk),
        .rst (rst),
        .bus (sw)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] hex_all();
        return {sw.hex5, sw.hex4, sw.hex3, sw.hex2, sw.hex1, sw.hex0};
    endfunction

    // Starts on the sample edge and follows one conversion through to its DONE edge.
    task automatic run_conversion(input string tag, input logic [23:0] exp_bcd,
                                  input logic [41:0] exp_hex, input logic exp_ovf);
        @(posedge clk); #1;
        check({tag, " busy_edge0"}, sw.busy, 1'b1);
        repeat (39) @(posedge clk);
        #1;
        check({tag, " done_edge39"}, sw.done, 1'b0);
        check({tag, " busy_edge39"}, sw.busy, 1'b1);
        @(posedge clk); #1;
        check({tag, " done_edge40"}, sw.done, 1'b1);
        check({tag, " busy_edge40"}, sw.busy, 1'b0);
        check({tag, " bcd"}, sw.bcd_out, exp_bcd);
        check({tag, " hex"}, hex_all(), exp_hex);
        check({tag, " ovf"}, sw.ovf, exp_ovf);
    endtask

    task automatic apply_stimulus(input logic [18:0] val);
        @(negedge clk);
        sw.time_in = val;
    endtask

    initial begin
        int activity;
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        sw.time_in = 19'd0;

        #35;
        check("reset hex", hex_all(), {6{7'h7F}});
        check("reset bcd", sw.bcd_out, 24'h0);
        check("reset busy", sw.busy, 1'b0);
        check("reset done", sw.done, 1'b0);
        check("reset ovf", sw.ovf, 1'b0);

        // First conversion runs even though time_in matches the reset last_val.
        @(negedge clk);
        rst = 1'b1;
        run_conversion("zero", 24'h000000, {6{7'h40}}, 1'b0);

        apply_stimulus(19'd12345);
        run_conversion("mixed", 24'h020345,
                       {7'h40, 7'h24, 7'h40, 7'h30, 7'h19, 7'h12}, 1'b0);

        apply_stimulus(19'd359999);
        run_conversion("max_ok", 24'h595999,
                       {7'h12, 7'h10, 7'h12, 7'h10, 7'h10, 7'h10}, 1'b0);

        apply_stimulus(19'd360000);
        run_conversion("first_ovf", 24'hFFFFFF, {6{7'h3F}}, 1'b1);

        apply_stimulus(19'd524287);
        run_conversion("top_ovf", 24'hFFFFFF, {6{7'h3F}}, 1'b1);

        // Change during conversion is held off until the next sample edge.
        apply_stimulus(19'd100);
        @(posedge clk); #1;
        check("mid busy_edge0", sw.busy, 1'b1);
        repeat (10) @(posedge clk);
        sw.time_in = 19'd6000;
        repeat (30) @(posedge clk);
        #1;
        check("mid first_done", sw.done, 1'b1);
        check("mid first_bcd", sw.bcd_out, 24'h000100);
        check("mid first_ovf", sw.ovf, 1'b0);
        @(posedge clk); #1;
        check("mid resample_busy", sw.busy, 1'b1);
        check("mid resample_done", sw.done, 1'b0);
        repeat (39) @(posedge clk);
        #1;
        check("mid second_early", sw.done, 1'b0);
        @(posedge clk); #1;
        check("mid second_done", sw.done, 1'b1);
        check("mid second_bcd", sw.bcd_out, 24'h010000);
        check("mid second_hex", hex_all(),
              {7'h40, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40});

        activity = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (sw.busy || sw.done) activity++;
        end
        check("idle activity", 64'(activity), 64'd0);
        check("idle bcd_hold", sw.bcd_out, 24'h010000);

        // Reset partway through a conversion discards it.
        apply_stimulus(19'd6099);
        repeat (21) @(posedge clk);
        #1;
        check("abort busy_before", sw.busy, 1'b1);
        rst = 1'b0;
        #1;
        check("abort bcd", sw.bcd_out, 24'h0);
        check("abort hex", hex_all(), {6{7'h7F}});
        check("abort busy", sw.busy, 1'b0);
        check("abort done", sw.done, 1'b0);
        check("abort ovf", sw.ovf, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run_conversion("after_abort", 24'h010099,
                       {7'h40, 7'h79, 7'h40, 7'h40, 7'h10, 7'h10}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
